fft_output_reorder: RTL and testbench
=====================================

Name: fft_output_reorder

Overview:
- Sits directly downstream of the 8-point radix-2 butterfly stage and consumes its serialized result stream.
- The butterfly stage emits one frame of N complex bins in bit-reversed order. This block buffers each frame, reorders it into natural order, and streams it out with a valid/ready handshake.
- Storage is ping-pong (two frame banks), so a new frame can be written while the previous frame is read. Sustained throughput is one sample per cycle.

Parameters:
- SIZE_OF_SIGNAL, 50: packed complex sample width. Real part in [SIZE_OF_SIGNAL-1:SIZE_OF_SIGNAL/2], imaginary part in [SIZE_OF_SIGNAL/2-1:0], both signed. The block passes data through unmodified.
- LOG2_N, 3: log2 of frame length. N = 2**LOG2_N = 8.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  block can accept an input sample.
- in_data_i  in  SIZE_OF_SIGNAL  input sample; frame-relative arrival order is bit-reversed.
- in_last_i  in  1  marks the final sample of an input frame.
- out_valid_o  out  1  out_data_o holds a valid sample.
- out_ready_i  in  1  downstream accepts the output sample.
- out_data_o  out  SIZE_OF_SIGNAL  output sample, natural order.
- out_index_o  out  LOG2_N  natural bin index of out_data_o.
- out_last_o  out  1  high with bin N-1.
- err_o  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (rst_i low at a clock edge):
  - wr_cnt, rd_cnt, wr_bank, rd_bank = 0; bank_full[1:0] = 0.
  - out_valid_o = 0, out_data_o = 0, out_index_o = 0, out_last_o = 0, err_o = 0.
  - in_ready_o = 1 from the first cycle after reset.
  - Memory contents are not reset.
  - Reset mid-frame discards all buffered and partial frames.
- Write side:
  - Handshake: accept = in_valid_i & in_ready_o; in_ready_o = !bank_full[wr_bank] (combinational from registers only).
  - On accept: mem[wr_bank][bitrev(wr_cnt)] <= in_data_i, where bitrev reverses LOG2_N bits.
  - wr_cnt == N-1 with in_last_i = 1: frame complete. bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
  - wr_cnt < N-1 with in_last_i = 0: wr_cnt increments.
- Framing errors:
  - Early last (in_last_i = 1 at wr_cnt < N-1): err_o pulses; partial frame discarded (wr_cnt <= 0, bank stays not-full).
  - Missing last (in_last_i = 0 at wr_cnt == N-1): err_o pulses; frame still committed as complete.
- Read side:
  - Load condition: bank_full[rd_bank] & (!out_valid_o | out_ready_i).
  - On load: out_data_o <= mem[rd_bank][rd_cnt], out_index_o <= rd_cnt, out_last_o <= (rd_cnt == N-1), out_valid_o <= 1.
  - After loading rd_cnt == N-1: bank_full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0. Otherwise rd_cnt increments.
  - If out_valid_o & out_ready_i and no load occurs: out_valid_o <= 0.
  - While out_valid_o & !out_ready_i, all outputs hold stable.
- Latency: first output valid the cycle after the last input of a frame is accepted (1-cycle latency from frame completion).
- Simultaneous events:
  - Set and clear of bank_full always target different banks and both take effect.
  - Writer refills a bank the cycle after the reader frees it (no bypass).
  - With both banks full, in_ready_o = 0 until the reader finishes its bank.
- Throughput: continuous input plus out_ready_i held high gives no input stalls after the first frame.

Test Plan:
- Single frame: after reset, feed re parts 0..7 in arrival order with in_last_i on the 8th sample, out_ready_i = 1 -> out_data_o re sequence 0,4,2,6,1,5,3,7; out_index_o 0..7; out_last_o only on index 7; first out_valid_o one cycle after last accept.
- Back-to-back: 4 frames with continuous in_valid_i and out_ready_i = 1 -> in_ready_o never drops; 32 outputs contiguous; each frame correctly reordered.
- Backpressure: hold out_ready_i = 0 while 2 frames arrive -> in_ready_o = 0 on the first sample of the 3rd frame; out_data_o stays at frame-0 bin 0 unchanged. Release out_ready_i -> 16 ordered outputs, then in_ready_o = 1.
- Early last: in_last_i on the 5th sample -> err_o high exactly one cycle; no output produced; next full frame reorders correctly.
- Missing last: 8 samples with in_last_i = 0 -> err_o pulse on the 8th sample; frame still output in order.
- Reset mid-operation: rst_i = 0 during output of frame at index 3 -> next cycle out_valid_o = 0, in_ready_o = 1; a subsequent frame is output from index 0.

Source files
------------

// File: rtl/fft_output_reorder.sv
// Ping-pong frame buffer that turns the bit-reversed butterfly output stream
// into natural bin order behind a valid/ready handshake.
module fft_output_reorder #(
    parameter int unsigned SIZE_OF_SIGNAL = 50,
    parameter int unsigned LOG2_N         = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [SIZE_OF_SIGNAL-1:0] in_data_i,
    input  logic                      in_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SIZE_OF_SIGNAL-1:0] out_data_o,
    output logic [LOG2_N-1:0]         out_index_o,
    output logic                      out_last_o,
    output logic                      err_o
);

    localparam int unsigned N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_CNT = LOG2_N'(N - 1);

    // Reverse the LOG2_N address bits of a frame-relative sample position.
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] x);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LOG2_N); i++) begin
            r[i] = x[int'(LOG2_N) - 1 - i];
        end
        return r;
    endfunction

    logic [SIZE_OF_SIGNAL-1:0] mem_q [2][N];

    logic [LOG2_N-1:0]         wr_cnt_q, wr_cnt_d;
    logic [LOG2_N-1:0]         rd_cnt_q, rd_cnt_d;
    logic                      wr_bank_q, wr_bank_d;
    logic                      rd_bank_q, rd_bank_d;
    logic [1:0]                bank_full_q, bank_full_d;
    logic                      out_valid_q, out_valid_d;
    logic [SIZE_OF_SIGNAL-1:0] out_data_q, out_data_d;
    logic [LOG2_N-1:0]         out_index_q, out_index_d;
    logic                      out_last_q, out_last_d;
    logic                      err_q, err_d;

    logic accept_c;
    logic load_c;

    assign in_ready_o  = !bank_full_q[wr_bank_q];
    assign accept_c    = in_valid_i & in_ready_o;
    assign load_c      = bank_full_q[rd_bank_q] & (!out_valid_q | out_ready_i);

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_index_o = out_index_q;
    assign out_last_o  = out_last_q;
    assign err_o       = err_q;

    // Scatter incoming samples to their natural-order slot in the write bank.
    always_ff @(posedge clk_i) begin
        if (rst_i && accept_c) begin
            mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data_i;
        end
    end

    // Next-state: write framing, bank occupancy and the output register stage.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        if (accept_c) begin
            if (wr_cnt_q == LAST_CNT) begin
                // A full count always commits; a missing last is only flagged.
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = !wr_bank_q;
                wr_cnt_d               = '0;
                err_d                  = !in_last_i;
            end else if (in_last_i) begin
                // Short frame: drop it and restart in the same bank.
                wr_cnt_d = '0;
                err_d    = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + LOG2_N'(1);
            end
        end

        if (load_c) begin
            out_data_d  = mem_q[rd_bank_q][rd_cnt_q];
            out_index_d = rd_cnt_q;
            out_last_d  = (rd_cnt_q == LAST_CNT);
            out_valid_d = 1'b1;
            if (rd_cnt_q == LAST_CNT) begin
                // Writer and reader never own the same bank, so this cannot
                // collide with the set above.
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = !rd_bank_q;
                rd_cnt_d               = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + LOG2_N'(1);
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder: single frame, back-to-back frames,
// backpressure, framing errors and reset during readout.
module tb_fft_output_reorder;

    localparam int unsigned W  = 50;
    localparam int unsigned H  = 25;
    localparam int unsigned LN = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_data_i;
    logic          in_last_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  out_data_o;
    logic [LN-1:0] out_index_o;
    logic          out_last_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    fft_output_reorder #(.SIZE_OF_SIGNAL(W), .LOG2_N(LN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_index_o(out_index_o),
        .out_last_o(out_last_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [W-1:0]  d;
        logic [LN-1:0] idx;
        logic          last;
    } exp_t;

    int     errors = 0;
    int     checks = 0;
    int     br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    exp_t   exp_q [$];
    logic [W-1:0] mdl [8];
    int     wcnt   = 0;
    logic   acc;
    int     stalls = 0;
    int     beats  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int re, input int im);
        return {H'(re), H'(im)};
    endfunction

    // One clock: score the output beat and input accept that this edge performs.
    task automatic tick();
        logic          xfer;
        logic          rst_pre;
        logic          e_err;
        exp_t          e;
        xfer    = out_valid_o & out_ready_i;
        acc     = in_valid_i & in_ready_o;
        rst_pre = !rst_i;
        e_err   = 1'b0;
        if (in_valid_i && !in_ready_o) stalls++;
        if (rst_pre) begin
            exp_q.delete();
            wcnt = 0;
        end else begin
            if (xfer) begin
                beats++;
                chk("out_present", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_beat", 64'({out_data_o, out_index_o, out_last_o}), 64'(e));
                end
            end
            if (acc) begin
                mdl[wcnt] = in_data_i;
                if (wcnt == 7) begin
                    for (int i = 0; i < 8; i++) begin
                        e.d    = mdl[br[i]];
                        e.idx  = LN'(i);
                        e.last = (i == 7);
                        exp_q.push_back(e);
                    end
                    wcnt  = 0;
                    e_err = !in_last_i;
                end else if (in_last_i) begin
                    wcnt  = 0;
                    e_err = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
        @(posedge clk_i);
        #1;
        chk("err_o", 64'(err_o), 64'(e_err));
    endtask

    // Present n samples (re = base+j), in_last on sample last_at (-1 for none).
    task automatic send_frame(input int base, input int n, input int last_at);
        int t;
        for (int j = 0; j < n; j++) begin
            in_valid_i = 1'b1;
            in_data_i  = mk(base + j, 1000 + base + j);
            in_last_i  = (j == last_at);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 100) begin
                tick();
                t++;
            end
            if (!acc) begin
                chk("in_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            tick();
            t++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int t;
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data",  64'(out_data_o),  64'd0);
        chk("rst_out_index", 64'(out_index_o), 64'd0);
        chk("rst_out_last",  64'(out_last_o),  64'd0);
        chk("rst_in_ready",  64'(in_ready_o),  64'd1);

        // Single frame: natural-order output starts one cycle after commit.
        send_frame(0, 8, 7);
        chk("single_valid_at_commit", 64'(out_valid_o), 64'd0);
        tick();
        chk("single_first_valid", 64'(out_valid_o), 64'd1);
        chk("single_first_index", 64'(out_index_o), 64'd0);
        chk("single_first_data",  64'(out_data_o),  64'(mk(0, 1000)));
        drain();

        // Back-to-back: four frames with no input stall.
        stalls = 0;
        beats  = 0;
        for (int f = 0; f < 4; f++) send_frame(16 * (f + 1), 8, 7);
        drain();
        chk("b2b_no_stall", 64'(stalls), 64'd0);
        chk("b2b_beats", 64'(beats), 64'd32);

        // Backpressure: two frames fill both banks, third frame is held off.
        out_ready_i = 1'b0;
        send_frame(100, 8, 7);
        send_frame(120, 8, 7);
        chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
        chk("bp_out_valid",    64'(out_valid_o), 64'd1);
        chk("bp_out_index",    64'(out_index_o), 64'd0);
        chk("bp_out_data",     64'(out_data_o),  64'(mk(100, 1100)));
        in_valid_i = 1'b1;
        in_data_i  = mk(140, 1140);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_ready", 64'(in_ready_o), 64'd0);
            chk("bp_hold_data",  64'(out_data_o), 64'(mk(100, 1100)));
        end
        beats = 0;
        out_ready_i = 1'b1;
        send_frame(140, 8, 7);
        drain();
        chk("bp_beats", 64'(beats), 64'd24);
        chk("bp_in_ready_after", 64'(in_ready_o), 64'd1);

        // Early last: error pulse, nothing output, next frame clean.
        send_frame(160, 5, 4);
        chk("early_err_high", 64'(err_o), 64'd1);
        tick();
        chk("early_err_low", 64'(err_o), 64'd0);
        tick();
        tick();
        chk("early_no_output", 64'(out_valid_o), 64'd0);
        send_frame(180, 8, 7);
        drain();

        // Missing last: error pulse, frame still delivered.
        send_frame(200, 8, -1);
        chk("miss_err_high", 64'(err_o), 64'd1);
        tick();
        chk("miss_err_low", 64'(err_o), 64'd0);
        chk("miss_out_valid", 64'(out_valid_o), 64'd1);
        drain();

        // Reset while bin 3 is on the output.
        send_frame(220, 8, 7);
        t = 0;
        while (!(out_valid_o && out_index_o == 3) && t < 50) begin
            tick();
            t++;
        end
        chk("rst_mid_reached_idx3", 64'(out_valid_o && out_index_o == 3), 64'd1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("rst_mid_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_mid_in_ready",  64'(in_ready_o),  64'd1);
        tick();
        chk("rst_mid_no_stale", 64'(out_valid_o), 64'd0);
        send_frame(240, 8, 7);
        tick();
        chk("rst_mid_restart_valid", 64'(out_valid_o), 64'd1);
        chk("rst_mid_restart_index", 64'(out_index_o), 64'd0);
        chk("rst_mid_restart_data",  64'(out_data_o),  64'(mk(240, 1240)));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
